// File: rtl/dcache_refill.sv
// Data-cache line refill engine: invalidates the tag, fetches one 32B line
// over an AXI INCR burst, writes each word into the data RAM, then marks the
// tag valid and acknowledges the miss.
module dcache_refill #(
    parameter logic [3:0]  ARID       = 4'd1,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        miss_req,
    input  logic [31:0] miss_addr,
    input  logic        tag_work,
    output logic        miss_ack,
    output logic        busy,

    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_id,
    output logic [7:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,

    input  logic        r_valid,
    output logic        r_ready,
    input  logic        r_last,
    input  logic [31:0] r_data,

    output logic        data_we,
    output logic [7:0]  data_index,
    output logic [2:0]  data_word,
    output logic [31:0] data_wdata,

    output logic [3:0]  tag_wen,
    output logic [7:0]  tag_index,
    output logic [19:0] tag_wdata,

    output logic        proto_err
);

    localparam int unsigned BEAT_W = 3;
    localparam int unsigned LINE_W = 27;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV,
        S_ADDR,
        S_DATA,
        S_TAG,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [LINE_W-1:0]   line_q;
    logic [BEAT_W-1:0]   cnt;
    logic                accept;
    logic                beat;

    // Byte offset within the line is irrelevant to a whole-line refill.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^miss_addr[4:0];

    assign accept = (state == S_IDLE) && miss_req && tag_work;
    assign beat   = (state == S_DATA) && r_valid;

    // Fixed burst attributes and address-derived RAM indices.
    assign ar_id      = ARID;
    assign ar_len     = 8'(LINE_WORDS - 1);
    assign ar_size    = 3'd2;
    assign ar_burst   = 2'b01;
    assign ar_addr    = {line_q, 5'b0};
    assign tag_index  = line_q[7:0];
    assign data_index = line_q[7:0];
    assign data_word  = cnt;
    assign data_wdata = r_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Line address capture, beat counter and sticky r_last checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q    <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                line_q <= miss_addr[31:5];
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
                if (r_last != (cnt == LAST_BEAT)) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_n   = state;
        busy      = 1'b1;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        data_we   = 1'b0;
        tag_wen   = 4'h0;
        tag_wdata = 20'h0;
        miss_ack  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (miss_req && tag_work) begin
                    state_n = S_INV;
                end
            end
            S_INV: begin
                tag_wen = 4'hF;
                state_n = S_ADDR;
            end
            S_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    data_we = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_n = S_TAG;
                    end
                end
            end
            S_TAG: begin
                tag_wen   = 4'hF;
                tag_wdata = {1'b1, line_q[LINE_W-1:8]};
                state_n   = S_DONE;
            end
            S_DONE: begin
                miss_ack = 1'b1;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_refill.sv
// Directed bench for dcache_refill: plays the AXI slave, logs RAM writes,
// and checks each scenario against hand-computed values.
module tb_dcache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        tag_work;
    logic        miss_ack;
    logic        busy;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic        r_last;
    logic [31:0] r_data;
    logic        data_we;
    logic [7:0]  data_index;
    logic [2:0]  data_word;
    logic [31:0] data_wdata;
    logic [3:0]  tag_wen;
    logic [7:0]  tag_index;
    logic [19:0] tag_wdata;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    dcache_refill #(.ARID(4'd1), .LINE_WORDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .tag_work   (tag_work),
        .miss_ack   (miss_ack),
        .busy       (busy),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_id      (ar_id),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .ar_burst   (ar_burst),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_last     (r_last),
        .r_data     (r_data),
        .data_we    (data_we),
        .data_index (data_index),
        .data_word  (data_word),
        .data_wdata (data_wdata),
        .tag_wen    (tag_wen),
        .tag_index  (tag_index),
        .tag_wdata  (tag_wdata),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Write/handshake recorder, sampled mid-cycle.
    int          cyc     = 0;
    logic [42:0] wr_log [64];
    int          wr_n    = 0;
    int          vt_n    = 0;
    logic [27:0] vt_last = '0;
    int          inv_n   = 0;
    int          inv_at  = 0;
    logic [27:0] inv_last = '0;
    logic [3:0]  wen_last = '0;
    int          ack_n   = 0;
    int          ar_chg  = 0;
    logic        ar_pv   = 1'b0;
    logic [31:0] ar_pa   = '0;
    logic [31:0] ar_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_we) begin
            wr_log[wr_n[5:0]] <= {data_index, data_word, data_wdata};
            wr_n <= wr_n + 1;
        end
        if (tag_wen != 4'h0) begin
            wen_last <= tag_wen;
            if (tag_wdata[19]) begin
                vt_n    <= vt_n + 1;
                vt_last <= {tag_index, tag_wdata};
            end else begin
                inv_n    <= inv_n + 1;
                inv_at   <= wr_n;
                inv_last <= {tag_index, tag_wdata};
            end
        end
        if (miss_ack) ack_n <= ack_n + 1;
        if (ar_valid && ar_pv && (ar_addr != ar_pa)) ar_chg <= ar_chg + 1;
        if (ar_valid) ar_last <= ar_addr;
        ar_pv <= ar_valid;
        ar_pa <= ar_addr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int t0        = 0;
    int ack_cycle = 0;

    // Drives one refill as AXI slave from the current post-edge point; returns
    // in the DONE cycle, or right after raising rst when rst_after beats are taken.
    task automatic serve(input logic [31:0] addr, input int ar_delay, input bit gappy,
                         input int last_at, input int rst_after, input bit chain,
                         input logic [31:0] next_addr);
        int ar_wait = 0;
        int bt      = 0;
        bit hs;
        bit acc     = 1'b0;
        bit done    = 1'b0;
        bit tog     = 1'b0;
        miss_addr = addr;
        miss_req  = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            if (busy && !acc) begin
                acc       = 1'b1;
                t0        = cyc;
                miss_addr = ~addr;
            end
            if (miss_ack) begin
                done      = 1'b1;
                ack_cycle = cyc - t0 + 1;
                r_valid   = 1'b0;
                ar_ready  = 1'b0;
                if (chain) miss_addr = next_addr;
                else       miss_req  = 1'b0;
            end else begin
                ar_ready = (ar_delay == 0) ? 1'b1 : (ar_valid && (ar_wait >= ar_delay));
                if (ar_valid) ar_wait++;
                tog     = ~tog;
                r_valid = gappy ? tog : 1'b1;
                r_data  = 32'(bt);
                r_last  = (bt == last_at);
                #1;
                hs = r_valid && r_ready;
                @(posedge clk);
                #1;
                if (hs) bt++;
                if (rst_after > 0 && bt == rst_after) begin
                    done     = 1'b1;
                    rst      = 1'b1;
                    r_valid  = 1'b0;
                    ar_ready = 1'b0;
                    miss_req = 1'b0;
                end
            end
        end
        chk("serve_complete", 64'(done), 64'(1));
    endtask

    initial begin
        int base_wr;
        int base_vt;
        int base_ack;
        int bad;

        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; tag_work = 1'b1;
        ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_data = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state and fixed burst attributes.
        chk("rst_busy",     64'(busy),      64'(0));
        chk("rst_ar_valid", 64'(ar_valid),  64'(0));
        chk("rst_r_ready",  64'(r_ready),   64'(0));
        chk("rst_data_we",  64'(data_we),   64'(0));
        chk("rst_tag_wen",  64'(tag_wen),   64'(0));
        chk("rst_miss_ack", 64'(miss_ack),  64'(0));
        chk("rst_proto",    64'(proto_err), 64'(0));
        chk("ar_id",        64'(ar_id),     64'(4'd1));
        chk("ar_len",       64'(ar_len),    64'(8'd7));
        chk("ar_size",      64'(ar_size),   64'(3'd2));
        chk("ar_burst",     64'(ar_burst),  64'(2'b01));
        rst = 1'b0;
        @(posedge clk); #1;

        // Minimum-latency refill of 0x8000_1234; INV counts as cycle 1.
        base_wr = wr_n; base_vt = vt_n; base_ack = ack_n;
        serve(32'h8000_1234, 0, 1'b0, 7, 0, 1'b0, 32'h0);
        chk("basic_ack_cycle", 64'(ack_cycle), 64'(12));
        @(posedge clk); #1;
        chk("basic_ar_addr",  64'(ar_last),  64'(32'h8000_1220));
        chk("basic_ar_chg",   64'(ar_chg),   64'(0));
        chk("basic_inv",      64'(inv_last), 64'({8'h91, 20'h00000}));
        chk("basic_inv_wen",  64'(wen_last), 64'(4'hF));
        chk("basic_inv_first",64'(inv_at),   64'(base_wr));
        chk("basic_nwr",      64'(wr_n - base_wr), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic_word%0d", i), 64'(wr_log[6'(base_wr + i)]),
                64'({8'h91, 3'(i), 32'(i)}));
        end
        chk("basic_vt_n",  64'(vt_n - base_vt),   64'(1));
        chk("basic_vt",    64'(vt_last),          64'({8'h91, 20'hC0000}));
        chk("basic_ack_n", 64'(ack_n - base_ack), 64'(1));
        chk("basic_idle",  64'(busy),             64'(0));
        chk("basic_proto", 64'(proto_err),        64'(0));

        // No acceptance while the tag store is still clearing.
        tag_work = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_0100; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) bad++;
        end
        chk("tw_idle", 64'(bad), 64'(0));
        tag_work = 1'b1;
        @(posedge clk); #1;
        chk("tw_accept", 64'(busy), 64'(1));
        base_vt = vt_n;
        serve(32'h0000_0100, 0, 1'b0, 7, 0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("tw_vt", 64'(vt_last), 64'({8'h08, 20'h80000}));

        // Slow address handshake and gappy read data.
        base_wr = wr_n; base_ack = ack_n;
        serve(32'h1111_2222, 5, 1'b1, 7, 0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("slow_ar_addr", 64'(ar_last), 64'(32'h1111_2220));
        chk("slow_ar_chg",  64'(ar_chg),  64'(0));
        chk("slow_nwr",     64'(wr_n - base_wr),   64'(8));
        chk("slow_word7",   64'(wr_log[6'(base_wr + 7)]), 64'({8'h11, 3'd7, 32'd7}));
        chk("slow_ack_n",   64'(ack_n - base_ack), 64'(1));
        chk("slow_vt",      64'(vt_last), 64'({8'h11, 20'h88889}));

        // Early r_last: error is sticky, the burst still runs 8 beats.
        base_wr = wr_n; base_vt = vt_n;
        serve(32'h0000_0040, 0, 1'b0, 3, 0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("plast_proto", 64'(proto_err),       64'(1));
        chk("plast_nwr",   64'(wr_n - base_wr),  64'(8));
        chk("plast_vt_n",  64'(vt_n - base_vt),  64'(1));
        chk("plast_vt",    64'(vt_last),         64'({8'h02, 20'h80000}));
        @(posedge clk); #1;
        chk("plast_sticky", 64'(proto_err), 64'(1));

        // Reset during DATA after beat 4.
        base_wr = wr_n; base_vt = vt_n; base_ack = ack_n;
        serve(32'h0000_3A40, 0, 1'b0, 7, 5, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy",     64'(busy),      64'(0));
        chk("mrst_ar_valid", 64'(ar_valid),  64'(0));
        chk("mrst_r_ready",  64'(r_ready),   64'(0));
        chk("mrst_data_we",  64'(data_we),   64'(0));
        chk("mrst_tag_wen",  64'(tag_wen),   64'(0));
        chk("mrst_miss_ack", 64'(miss_ack),  64'(0));
        chk("mrst_proto",    64'(proto_err), 64'(0));
        chk("mrst_inv",      64'(inv_last),  64'({8'hD2, 20'h00000}));
        chk("mrst_inv_first",64'(inv_at),    64'(base_wr));
        chk("mrst_nwr",      64'(wr_n - base_wr),   64'(5));
        chk("mrst_no_vt",    64'(vt_n - base_vt),   64'(0));
        chk("mrst_no_ack",   64'(ack_n - base_ack), 64'(0));
        @(posedge clk); #1;

        // Back-to-back misses to index 0xFF then 0x00.
        serve(32'h0000_1FE0, 0, 1'b0, 7, 0, 1'b1, 32'h1234_6000);
        chk("b2b_vt1", 64'(vt_last), 64'({8'hFF, 20'h80000}));
        @(posedge clk); #1;
        chk("b2b_gap", 64'(busy), 64'(0));
        @(posedge clk); #1;
        chk("b2b_accept", 64'(busy), 64'(1));
        serve(32'h1234_6000, 0, 1'b0, 7, 0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("b2b_inv2", 64'(inv_last), 64'({8'h00, 20'h00000}));
        chk("b2b_vt2",  64'(vt_last),  64'({8'h00, 20'h891A3}));
        chk("b2b_ar2",  64'(ar_last),  64'(32'h1234_6000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
